// File: rtl/conv_mac_seq_controller.sv
// rtl/conv_mac_seq_controller.sv - KxK multi-channel strided convolution MAC sequencer
`timescale 1ns/1ps
module conv_mac_seq_controller #(
    parameter int DATA_SIZE           = 8,
    parameter int OUT_DATA_SIZE       = 24,
    parameter int IMG_SIZE            = 128,
    parameter int KERNEL              = 5,
    parameter int CHANNELS            = 1,
    parameter int STRIDE              = 1,
    parameter int IMG_ADDRESS_SIZE    = 18,
    parameter int WEIGHT_ADDRESS_SIZE = 10,
    parameter int OUT_ADDRESS_SIZE    = 14
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           relu_en,
    input  logic [DATA_SIZE-1:0]           img_data,
    input  logic [DATA_SIZE-1:0]           weight_data,
    output logic [IMG_ADDRESS_SIZE-1:0]    img_address,
    output logic [WEIGHT_ADDRESS_SIZE-1:0] weight_address,
    output logic                           img_data_ena,
    output logic                           weight_data_ena,
    input  logic                           out_ready,
    output logic                           data_validity,
    output logic [OUT_ADDRESS_SIZE-1:0]    out_address,
    output logic [OUT_DATA_SIZE-1:0]       out_data,
    output logic                           busy,
    output logic                           done
);

    localparam int OUT_SIZE = (IMG_SIZE - KERNEL) / STRIDE + 1;
    localparam int ACC_SIZE = 2 * DATA_SIZE + $clog2(KERNEL * KERNEL * CHANNELS);
    localparam int RW  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int KW  = (KERNEL > 1) ? $clog2(KERNEL) : 1;
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IA  = IMG_ADDRESS_SIZE;
    localparam int WA  = WEIGHT_ADDRESS_SIZE;
    localparam int OA  = OUT_ADDRESS_SIZE;
    localparam int WW  = (ACC_SIZE > OUT_DATA_SIZE) ? ACC_SIZE : OUT_DATA_SIZE;
    localparam logic signed [WW-1:0] SAT_MAX = WW'((64'sd1 <<< (OUT_DATA_SIZE - 1)) - 64'sd1);
    localparam logic signed [WW-1:0] SAT_MIN = -SAT_MAX - WW'(1);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, OUT, FIN} state_t;

    state_t state, state_next;

    logic [RW-1:0]  r, c;
    logic [CHW-1:0] ch;
    logic [KW-1:0]  kr, kc;
    logic           relu_q;
    logic           rd_valid, rd_first;
    logic signed [ACC_SIZE-1:0]    acc, acc_sum, relu_val;
    logic signed [2*DATA_SIZE-1:0] product;
    logic signed [WW-1:0]          wide;
    logic [OUT_DATA_SIZE-1:0]      fmt;
    logic last_tap, last_pix, first_tap;

    assign first_tap = (ch == '0) && (kr == '0) && (kc == '0);
    assign last_tap  = (ch == CHW'(CHANNELS - 1)) && (kr == KW'(KERNEL - 1)) && (kc == KW'(KERNEL - 1));
    assign last_pix  = (r == RW'(OUT_SIZE - 1)) && (c == RW'(OUT_SIZE - 1));

    assign img_address = IA'(ch) * IA'(IMG_SIZE * IMG_SIZE)
                       + (IA'(r) * IA'(STRIDE) + IA'(kr)) * IA'(IMG_SIZE)
                       + IA'(c) * IA'(STRIDE) + IA'(kc);
    assign weight_address = WA'(ch) * WA'(KERNEL * KERNEL) + WA'(kr) * WA'(KERNEL) + WA'(kc);
    assign out_address    = OA'(r) * OA'(OUT_SIZE) + OA'(c);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next      = state;
        busy            = 1'b0;
        done            = 1'b0;
        data_validity   = 1'b0;
        img_data_ena    = 1'b0;
        weight_data_ena = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy            = 1'b1;
                img_data_ena    = 1'b1;
                weight_data_ena = 1'b1;
                if (last_tap) state_next = DRAIN;
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = OUT;
            end
            OUT: begin
                busy          = 1'b1;
                data_validity = 1'b1;
                if (out_ready) state_next = last_pix ? FIN : RUN;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r      <= '0;
            c      <= '0;
            ch     <= '0;
            kr     <= '0;
            kc     <= '0;
            relu_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    r      <= '0;
                    c      <= '0;
                    ch     <= '0;
                    kr     <= '0;
                    kc     <= '0;
                    relu_q <= relu_en;
                end
                RUN: begin
                    if (kc == KW'(KERNEL - 1)) begin
                        kc <= '0;
                        if (kr == KW'(KERNEL - 1)) begin
                            kr <= '0;
                            if (ch == CHW'(CHANNELS - 1)) ch <= '0;
                            else                          ch <= ch + CHW'(1);
                        end else begin
                            kr <= kr + KW'(1);
                        end
                    end else begin
                        kc <= kc + KW'(1);
                    end
                end
                OUT: if (out_ready && !last_pix) begin
                    ch <= '0;
                    kr <= '0;
                    kc <= '0;
                    if (c == RW'(OUT_SIZE - 1)) begin
                        c <= '0;
                        r <= r + RW'(1);
                    end else begin
                        c <= c + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // BRAM data lags the address by one cycle, so the tap-valid and first-tap flags lag too.
    assign product = signed'(img_data) * signed'(weight_data);
    assign acc_sum = (rd_first ? ACC_SIZE'(0) : acc) + ACC_SIZE'(product);

    always_comb begin
        relu_val = (relu_q && acc_sum < 0) ? ACC_SIZE'(0) : acc_sum;
        wide     = WW'(relu_val);
        if (wide > SAT_MAX)      fmt = OUT_DATA_SIZE'(SAT_MAX);
        else if (wide < SAT_MIN) fmt = OUT_DATA_SIZE'(SAT_MIN);
        else                     fmt = OUT_DATA_SIZE'(wide);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_first <= 1'b0;
            acc      <= '0;
            out_data <= '0;
        end else begin
            rd_valid <= img_data_ena;
            rd_first <= img_data_ena && first_tap;
            if (rd_valid) acc <= acc_sum;
            if (state == DRAIN) out_data <= fmt;
        end
    end

endmodule

// File: tb/tb_conv_mac_seq_controller.sv
// tb/tb_conv_mac_seq_controller.sv - scoreboard bench for conv_mac_seq_controller
`timescale 1ns/1ps
module tb_conv_mac_seq_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst[3], start[3], relu_en[3], out_ready[3];
    logic signed [7:0] img_rd[3], w_rd[3];
    logic [7:0]        img_address[3];
    logic [5:0]        weight_address[3];
    logic              img_ena[3], w_ena[3], valid[3], busy[3], done[3];
    logic [3:0]        out_address[3];
    logic [23:0]       od[3];
    logic [11:0]       od12;
    logic signed [7:0] img_mem[3][64];
    logic signed [7:0] w_mem[3][64];

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int exp_a[$];
    int addr_log[$];
    int waddr_log[$];
    int got[$];

    assign od[2] = 24'(signed'(od12));

    always @(posedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (img_ena[u] === 1'b1) img_rd[u] <= img_mem[u][img_address[u][5:0]];
            if (w_ena[u] === 1'b1)   w_rd[u]   <= w_mem[u][weight_address[u][5:0]];
        end
    end

    conv_mac_seq_controller #(.DATA_SIZE(8), .OUT_DATA_SIZE(24), .IMG_SIZE(5), .KERNEL(3), .CHANNELS(1),
        .STRIDE(1), .IMG_ADDRESS_SIZE(8), .WEIGHT_ADDRESS_SIZE(6), .OUT_ADDRESS_SIZE(4)) u0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .relu_en(relu_en[0]), .img_data(img_rd[0]),
        .weight_data(w_rd[0]), .img_address(img_address[0]), .weight_address(weight_address[0]),
        .img_data_ena(img_ena[0]), .weight_data_ena(w_ena[0]), .out_ready(out_ready[0]),
        .data_validity(valid[0]), .out_address(out_address[0]), .out_data(od[0]), .busy(busy[0]), .done(done[0]));

    conv_mac_seq_controller #(.DATA_SIZE(8), .OUT_DATA_SIZE(24), .IMG_SIZE(5), .KERNEL(3), .CHANNELS(2),
        .STRIDE(2), .IMG_ADDRESS_SIZE(8), .WEIGHT_ADDRESS_SIZE(6), .OUT_ADDRESS_SIZE(4)) u1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .relu_en(relu_en[1]), .img_data(img_rd[1]),
        .weight_data(w_rd[1]), .img_address(img_address[1]), .weight_address(weight_address[1]),
        .img_data_ena(img_ena[1]), .weight_data_ena(w_ena[1]), .out_ready(out_ready[1]),
        .data_validity(valid[1]), .out_address(out_address[1]), .out_data(od[1]), .busy(busy[1]), .done(done[1]));

    conv_mac_seq_controller #(.DATA_SIZE(8), .OUT_DATA_SIZE(12), .IMG_SIZE(5), .KERNEL(3), .CHANNELS(1),
        .STRIDE(1), .IMG_ADDRESS_SIZE(8), .WEIGHT_ADDRESS_SIZE(6), .OUT_ADDRESS_SIZE(4)) u2 (
        .clk(clk), .rst(rst[2]), .start(start[2]), .relu_en(relu_en[2]), .img_data(img_rd[2]),
        .weight_data(w_rd[2]), .img_address(img_address[2]), .weight_address(weight_address[2]),
        .img_data_ena(img_ena[2]), .weight_data_ena(w_ena[2]), .out_ready(out_ready[2]),
        .data_validity(valid[2]), .out_address(out_address[2]), .out_data(od12), .busy(busy[2]), .done(done[2]));

    function automatic int model_pix(input int u, input int p, input int osz, input int chans,
                                     input int s, input bit relu, input int ow);
        int r, c, sum, mx, mn;
        r = p / osz;
        c = p % osz;
        sum = 0;
        for (int ch = 0; ch < chans; ch++)
            for (int kr = 0; kr < 3; kr++)
                for (int kc = 0; kc < 3; kc++)
                    sum += int'(img_mem[u][ch*25 + (r*s + kr)*5 + c*s + kc]) * int'(w_mem[u][ch*9 + kr*3 + kc]);
        if (relu && sum < 0) sum = 0;
        mx = (1 << (ow - 1)) - 1;
        mn = -(1 << (ow - 1));
        if (sum > mx) sum = mx;
        if (sum < mn) sum = mn;
        return sum;
    endfunction

    task automatic fill(input int u, input int mode, input int wval, input int p1val);
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0: img_mem[u][i] = 8'sd1;
                1: img_mem[u][i] = 8'(i);
                2: img_mem[u][i] = (i < 25) ? 8'sd1 : 8'(p1val);
                default: img_mem[u][i] = 8'(p1val);
            endcase
            w_mem[u][i] = 8'(wval);
        end
    endtask

    task automatic run_frame(input int u, input bit relu, input int chans, input int s, input int ow,
                             input int hold_pix, input int hold_n);
        int osz, npix, cyc, pix, held, first_cyc, last_cyc, ed, ea;
        logic [23:0] hd;
        logic [3:0]  ha;
        logic [7:0]  hi;
        bit fin;
        osz = (5 - 3) / s + 1;
        npix = osz * osz;
        exp_q.delete(); exp_a.delete(); addr_log.delete(); waddr_log.delete(); got.delete();
        for (int p = 0; p < npix; p++) begin
            exp_q.push_back(model_pix(u, p, osz, chans, s, relu, ow));
            exp_a.push_back(p);
        end
        relu_en[u] = relu;
        out_ready[u] = 1'b1;
        start[u] = 1'b1;
        @(posedge clk); #1;
        start[u] = 1'b0;
        relu_en[u] = ~relu;
        cyc = 1; pix = 0; held = 0; first_cyc = -1; last_cyc = -1; fin = 0;
        hd = '0; ha = '0; hi = '0;
        checks++;
        if (busy[u] !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy[u]); end
        while (!fin && cyc < 3000) begin
            if (img_ena[u] === 1'b1) begin
                addr_log.push_back(int'(img_address[u]));
                waddr_log.push_back(int'(weight_address[u]));
            end
            if (valid[u] === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (pix == hold_pix && held < hold_n) begin
                    if (held == 0) begin
                        hd = od[u]; ha = out_address[u]; hi = img_address[u];
                    end else begin
                        checks++;
                        if (od[u] !== hd || out_address[u] !== ha || img_address[u] !== hi
                            || img_ena[u] !== 1'b0 || w_ena[u] !== 1'b0) begin
                            errors++;
                            $display("FAIL hold_stable: got data=%0d addr=%0d iaddr=%0d ena=%b%b want data=%0d addr=%0d iaddr=%0d ena=00",
                                     od[u], out_address[u], img_address[u], img_ena[u], w_ena[u], hd, ha, hi);
                        end
                    end
                    out_ready[u] = 1'b0;
                    held++;
                end else begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_output: got addr=%0d want no output", out_address[u]);
                    end else begin
                        ed = exp_q.pop_front();
                        ea = exp_a.pop_front();
                        if (od[u] !== 24'(ed) || out_address[u] !== 4'(ea)) begin
                            errors++;
                            $display("FAIL pixel_u%0d: got data=%0d addr=%0d want data=%0d addr=%0d",
                                     u, $signed(od[u]), out_address[u], ed, ea);
                        end
                    end
                    got.push_back(int'($signed(od[u])));
                    out_ready[u] = 1'b1;
                    pix++;
                    if (pix == npix) last_cyc = cyc;
                end
            end else begin
                out_ready[u] = 1'b1;
            end
            if (done[u] === 1'b1) begin
                fin = 1;
                checks++;
                if (last_cyc < 0 || cyc != last_cyc + 1) begin
                    errors++;
                    $display("FAIL done_timing: got cycle %0d want %0d", cyc, last_cyc + 1);
                end
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checks++;
        if (!fin) begin errors++; $display("FAIL frame_timeout: got no done want done"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL pending_outputs: got %0d left want 0", exp_q.size()); end
        checks++;
        if (first_cyc != 9 * chans + 2) begin
            errors++; $display("FAIL first_valid_cycle: got %0d want %0d", first_cyc, 9 * chans + 2);
        end
        checks++;
        if (addr_log.size() != npix * 9 * chans) begin
            errors++; $display("FAIL tap_count: got %0d want %0d", addr_log.size(), npix * 9 * chans);
        end
        @(posedge clk); #1;
        checks++;
        if (done[u] !== 1'b0 || busy[u] !== 1'b0 || valid[u] !== 1'b0) begin
            errors++; $display("FAIL idle_after_done: got done=%b busy=%b valid=%b want 000", done[u], busy[u], valid[u]);
        end
    endtask

    task automatic check_zero(input int u, input string tag);
        checks++;
        if (valid[u] !== 1'b0 || busy[u] !== 1'b0 || done[u] !== 1'b0 || img_ena[u] !== 1'b0
            || w_ena[u] !== 1'b0 || img_address[u] !== '0 || weight_address[u] !== '0
            || out_address[u] !== '0 || od[u] !== '0) begin
            errors++;
            $display("FAIL %s_u%0d: got v=%b b=%b d=%b ia=%0d wa=%0d oa=%0d od=%0d want all 0", tag, u,
                     valid[u], busy[u], done[u], img_address[u], weight_address[u], out_address[u], od[u]);
        end
    endtask

    task automatic test_reset();
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1; start[u] = 1'b0; relu_en[u] = 1'b0; out_ready[u] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) check_zero(u, "reset_state");
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ones();
        fill(0, 0, 1, 0);
        run_frame(0, 0, 1, 1, 24, -1, 0);
    endtask

    task automatic test_index();
        int exp_addr[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        fill(0, 1, 1, 0);
        run_frame(0, 0, 1, 1, 24, -1, 0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (addr_log.size() <= i || addr_log[i] != exp_addr[i]) begin
                errors++; $display("FAIL pix0_img_address[%0d]: got %0d want %0d", i,
                                   (addr_log.size() > i) ? addr_log[i] : -1, exp_addr[i]);
            end
        end
        checks++;
        if (got.size() != 9 || got[0] != 54 || got[8] != 162) begin
            errors++; $display("FAIL index_values: got %0d,%0d want 54,162",
                               (got.size() > 0) ? got[0] : -1, (got.size() > 8) ? got[8] : -1);
        end
    endtask

    task automatic test_channels_stride();
        fill(1, 2, 1, 2);
        run_frame(1, 0, 2, 2, 24, -1, 0);
        checks++;
        if (addr_log.size() < 28 || addr_log[18] != 2 || addr_log[27] != 27 || waddr_log[27] != 9) begin
            errors++; $display("FAIL pix1_addresses: got %0d,%0d,%0d want 2,27,9",
                               (addr_log.size() > 18) ? addr_log[18] : -1, (addr_log.size() > 27) ? addr_log[27] : -1,
                               (waddr_log.size() > 27) ? waddr_log[27] : -1);
        end
        checks++;
        if (got.size() != 4 || got[0] != 27 || got[3] != 27) begin
            errors++; $display("FAIL chan_values: got %0d want 27", (got.size() > 0) ? got[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        fill(0, 1, 1, 0);
        run_frame(0, 0, 1, 1, 24, 3, 5);
    endtask

    task automatic test_saturation();
        int want[3] = '{2047, 0, -2048};
        for (int t = 0; t < 3; t++) begin
            fill(2, 3, (t == 0) ? 127 : -127, 127);
            run_frame(2, t == 1, 1, 1, 12, -1, 0);
            checks++;
            if (got.size() == 0 || got[0] != want[t]) begin
                errors++; $display("FAIL saturate_%0d: got %0d want %0d", t, (got.size() > 0) ? got[0] : -1, want[t]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        bit bad;
        fill(0, 0, 1, 0);
        relu_en[0] = 1'b0;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b1 || img_address[0] !== 8'd6) begin
            errors++; $display("FAIL start_ignored: got busy=%b iaddr=%0d want busy=1 iaddr=6", busy[0], img_address[0]);
        end
        rst[0] = 1'b1;
        @(posedge clk); #1;
        check_zero(0, "mid_reset");
        rst[0] = 1'b0;
        bad = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL no_done_after_reset: got activity want none"); end
        run_frame(0, 0, 1, 1, 24, -1, 0);
    endtask

    initial begin
        test_reset();
        test_ones();
        test_index();
        test_channels_stride();
        test_backpressure();
        test_saturation();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_mac_seq_controller.md
Name: conv_mac_seq_controller

Overview:
- Parametrised successor to the fixed 5x5, single-channel, line-queue convolution controller.
- Computes a valid (no-padding) KERNELxKERNEL convolution over CHANNELS input planes with a configurable stride.
- Generates image and weight BRAM read addresses and accumulates one product per cycle.
- Emits each output pixel through a valid/ready handshake with optional ReLU and saturation; sits between the image/weight BRAMs and the output buffer writer.

Parameters:
DATA_SIZE, 8, width of image and weight samples (signed two's complement)
OUT_DATA_SIZE, 24, output sample width
IMG_SIZE, 128, square input plane width/height
KERNEL, 5, kernel width/height (1..7)
CHANNELS, 1, input planes accumulated into one output plane (1..16)
STRIDE, 1, output step in rows and columns (1 or 2)
IMG_ADDRESS_SIZE, 18, image address width (≥ clog2(CHANNELS*IMG_SIZE^2))
WEIGHT_ADDRESS_SIZE, 10, weight address width (≥ clog2(CHANNELS*KERNEL^2))
OUT_ADDRESS_SIZE, 14, output address width (≥ clog2(OUT_SIZE^2))

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a frame when idle
relu_en  input  1  sampled at start; clamps negative results to 0
img_data  input  DATA_SIZE  image BRAM read data, 1-cycle latency
weight_data  input  DATA_SIZE  weight BRAM read data, 1-cycle latency
img_address  output  IMG_ADDRESS_SIZE  image read address
weight_address  output  WEIGHT_ADDRESS_SIZE  weight read address
img_data_ena  output  1  image read enable
weight_data_ena  output  1  weight read enable
out_ready  input  1  downstream accepts out_data
data_validity  output  1  out_data/out_address valid
out_address  output  OUT_ADDRESS_SIZE  linear output index
out_data  output  OUT_DATA_SIZE  result sample
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse after the last output is accepted

Behaviour:
- Derived values:
  - OUT_SIZE = (IMG_SIZE-KERNEL)/STRIDE+1.
  - ACC_SIZE = 2*DATA_SIZE + clog2(KERNEL*KERNEL*CHANNELS).
- Reset: all outputs 0, state IDLE, accumulator and all counters 0. Reset mid-frame aborts immediately; no done pulse.
- Counters, nested outermost to innermost: row r, col c (0..OUT_SIZE-1), ch, kr, kc.
  - img_address = ch*IMG_SIZE^2 + (r*STRIDE+kr)*IMG_SIZE + c*STRIDE + kc.
  - weight_address = ch*KERNEL^2 + kr*KERNEL + kc.
  - out_address = r*OUT_SIZE + c.
- States:
  - IDLE: busy=0. On start, latch relu_en, clear counters, go to RUN. start is ignored in every other state.
  - RUN: one tap issued per cycle (both ena=1, addresses as above). The last tap (ch=CHANNELS-1, kr=kc=KERNEL-1) moves to DRAIN.
  - DRAIN: ena=0; the last data returns and is accumulated; go to OUT.
  - OUT: data_validity=1; out_data and out_address are held stable until out_ready=1 in the same cycle. On accept:
    - If r=c=OUT_SIZE-1, go to FIN.
    - Otherwise advance c (wrapping to 0 and incrementing r), clear ch/kr/kc, go to RUN.
  - FIN: done=1 for one cycle, busy=0; return to IDLE.
- Accumulate pipeline:
  - A read-valid flag is delayed one cycle from ena, together with a first-tap flag.
  - When set: acc <= (first ? 0 : acc) + signed(img_data)*signed(weight_data), full ACC_SIZE precision.
- Output formatting, registered on the DRAIN->OUT transition:
  - If relu, negative acc becomes 0.
  - Then saturate to the signed OUT_DATA_SIZE range (max 2^(OUT_DATA_SIZE-1)-1, min -2^(OUT_DATA_SIZE-1)).
- Throughput: KERNEL^2*CHANNELS + 2 cycles per pixel with out_ready held high. First data_validity comes KERNEL^2*CHANNELS+2 cycles after the start cycle.
- data_validity deasserts the cycle after acceptance. out_data keeps its last value when not valid.

Test Plan:
- IMG_SIZE=5, KERNEL=3, CHANNELS=1, STRIDE=1, all data=1, out_ready=1:
  - 9 outputs, each out_data=9, out_address 0..8 in order.
  - First valid at cycle 11 after start; done one cycle after address 8 is accepted.
- Same configuration, img value = linear index, weights = 1:
  - out_data[0]=54, out_data[8]=162.
  - img_address sequence for pixel 0 is 0,1,2,5,6,7,10,11,12.
- CHANNELS=2, STRIDE=2, IMG_SIZE=5, KERNEL=3, plane0=1, plane1=2, weights=1:
  - 4 outputs, each 27; pixel 1 addresses start at 2 and at 27 for ch1.
- Backpressure: out_ready held low 5 cycles at pixel 3 -> out_data/out_address stable, no reads issued, counters frozen; resumes correctly.
- Saturation and ReLU with OUT_DATA_SIZE=12, data=127, weight=127, KERNEL=3:
  - acc=145161 -> out_data=2047.
  - weight=-127 with relu_en=1 -> out_data=0; with relu_en=0 -> out_data=-2048.
- rst asserted mid-RUN, with start pulsed during RUN beforehand:
  - The start pulse has no effect.
  - After rst, all outputs are 0, no done pulse; a new start runs a full correct frame.
